pc_fetch_ctrl: RTL and testbench

//  Consumer side of the next-PC path: owns the architectural PC register, takes the next-PC

---
 rtl/pc_fetch_ctrl_pkg.sv | 23 ++
 rtl/pc_fetch_ctrl_if_reg.sv | 33 +++
 rtl/pc_fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared encodings for the fetch controller: next-PC opcodes, fetch FSM states and the NOP word.
package pc_fetch_ctrl_pkg;

   localparam int NPC_OP_W = 5;

   localparam logic [NPC_OP_W-1:0] NPC_PLUS4  = 5'b00000;
   localparam logic [NPC_OP_W-1:0] NPC_BRANCH = 5'b00001;
   localparam logic [NPC_OP_W-1:0] NPC_JUMP   = 5'b00010;
   localparam logic [NPC_OP_W-1:0] NPC_JALR   = 5'b00100;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_FETCH = 2'd1,
      FS_DRAIN = 2'd2
   } fetch_state_e;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if_reg.sv
// IF/ID pipeline register: clear has priority over load, load over hold; otherwise a bubble.
module pc_if_reg
   import pc_fetch_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        flush_i,
   input  logic        load_i,
   input  logic        hold_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] inst_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_o <= 1'b0;
         pc_o    <= 32'h0;
         inst_o  <= INST_NOP;
      end else if (flush_i) begin
         valid_o <= 1'b0;
      end else if (load_i) begin
         valid_o <= 1'b1;
         pc_o    <= pc_i;
         inst_o  <= inst_i;
      end else if (!hold_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, instruction-fetch handshake FSM and redirect/flush generation.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
   parameter int          NPCOP_W  = 5
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               stall_i,
   input  logic [NPCOP_W-1:0] npc_op_i,
   input  logic [31:0]        npc_i,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ready,
   input  logic [31:0]        imem_rdata,
   output logic               if_valid_o,
   output logic [31:0]        if_pc_o,
   output logic [31:0]        if_inst_o,
   output logic               flush_o,
   output logic               trap_o
);

   fetch_state_e state_q, state_next;
   logic [31:0]  pc_q, redir_q, target;
   logic         pend_q;
   logic         redirect, if_load, if_hold;

   assign redirect  = (state_q != FS_IDLE) && (npc_op_i != NPCOP_W'(NPC_PLUS4));
   assign imem_addr = pc_q;

`ifdef PC_MISALIGN_TRAP_EN
   logic misalign;
   assign misalign = (npc_i[1:0] != 2'b00);
   assign target   = misalign ? TRAP_VEC : npc_i;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) trap_o <= 1'b0;
      else       trap_o <= redirect && misalign;
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{npc_i[1:0], TRAP_VEC};
   assign target     = align_word(npc_i);
   assign trap_o     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= FS_IDLE;
      else       state_q <= state_next;
   end

   always_comb begin
      state_next = state_q;
      case (state_q)
         FS_IDLE:  state_next = FS_FETCH;
         FS_FETCH: if (redirect && imem_req && !imem_ready) state_next = FS_DRAIN;
         FS_DRAIN: if (imem_ready) state_next = FS_FETCH;
         default:  state_next = FS_IDLE;
      endcase
   end

   // A completion while stalled is dropped and refetched, so IF/ID stays frozen.
   always_comb begin
      imem_req = 1'b0;
      if_load  = 1'b0;
      if_hold  = 1'b1;
      case (state_q)
         FS_FETCH: begin
            imem_req = !stall_i || pend_q;
            if_load  = imem_req && imem_ready && !stall_i && !redirect;
            if_hold  = stall_i;
         end
         FS_DRAIN: begin
            imem_req = 1'b1;
            if_hold  = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_q    <= RESET_PC;
         redir_q <= 32'h0;
         pend_q  <= 1'b0;
         flush_o <= 1'b0;
      end else begin
         flush_o <= redirect;
         pend_q  <= (state_q == FS_FETCH) && imem_req && !imem_ready && !redirect;
         case (state_q)
            FS_FETCH: begin
               if (redirect) begin
                  if (imem_req && !imem_ready) redir_q <= target;
                  else                         pc_q    <= target;
               end else if (if_load) begin
                  pc_q <= pc_q + 32'd4;
               end
            end
            FS_DRAIN: begin
               // Latest redirect wins; it bypasses redir_q when the drain ends this cycle.
               if (redirect) begin
                  if (imem_ready) pc_q    <= target;
                  else            redir_q <= target;
               end else if (imem_ready) begin
                  pc_q <= redir_q;
               end
            end
            default: ;
         endcase
      end
   end

   pc_if_reg u_if_reg (
      .clk     (clk),
      .rstn    (rstn),
      .flush_i (redirect),
      .load_i  (if_load),
      .hold_i  (if_hold),
      .pc_i    (pc_q),
      .inst_i  (imem_rdata),
      .valid_o (if_valid_o),
      .pc_o    (if_pc_o),
      .inst_o  (if_inst_o)
   );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: fetched words are queued when the handshake is driven
// and popped one cycle later when IF/ID should present them.
module tb_pc_fetch_ctrl;
   import pc_fetch_ctrl_pkg::*;

`ifdef PC_MISALIGN_TRAP_EN
   localparam logic [31:0] MIS_ADDR = 32'h0000_0100;
   localparam logic        MIS_TRAP = 1'b1;
`else
   localparam logic [31:0] MIS_ADDR = 32'h0000_0040;
   localparam logic        MIS_TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        stall_i = 1'b0;
   logic [4:0]  npc_op_i = NPC_PLUS4;
   logic [31:0] npc_i = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b1;
   logic [31:0] imem_rdata;
   logic        if_valid_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        flush_o;
   logic        trap_o;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] sb[$];
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] exp_inst = INST_NOP;
   logic [31:0] p;

   always #5 clk = ~clk;

   pc_fetch_ctrl dut (
      .clk        (clk),
      .rstn       (rstn),
      .stall_i    (stall_i),
      .npc_op_i   (npc_op_i),
      .npc_i      (npc_i),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .if_valid_o (if_valid_o),
      .if_pc_o    (if_pc_o),
      .if_inst_o  (if_inst_o),
      .flush_o    (flush_o),
      .trap_o     (trap_o)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_reset();
      exp_pc   = 32'h0;
      exp_inst = INST_NOP;
      sb.delete();
      chk("rst_req",   {31'h0, imem_req},   32'h0);
      chk("rst_addr",  imem_addr,           32'h0);
      chk("rst_valid", {31'h0, if_valid_o}, 32'h0);
      chk("rst_if_pc", if_pc_o,             32'h0);
      chk("rst_inst",  if_inst_o,           INST_NOP);
      chk("rst_flush", {31'h0, flush_o},    32'h0);
      chk("rst_trap",  {31'h0, trap_o},     32'h0);
   endtask

   // One clock: drive inputs, check the request side, then check IF/ID after the edge.
   task automatic cyc(input logic st, input logic [4:0] op, input logic [31:0] npc,
                      input logic rdy, input logic e_req, input logic [31:0] e_addr,
                      input logic e_fetch, input logic e_valid, input logic e_flush,
                      input logic e_trap);
      stall_i    = st;
      npc_op_i   = op;
      npc_i      = npc;
      imem_ready = rdy;
      #1;
      chk("imem_req",  {31'h0, imem_req}, {31'h0, e_req});
      chk("imem_addr", imem_addr, e_addr);
      if (e_fetch) sb.push_back({e_addr, mem_word(e_addr)});
      @(posedge clk);
      #1;
      if (e_fetch) {exp_pc, exp_inst} = sb.pop_front();
      chk("if_valid", {31'h0, if_valid_o}, {31'h0, e_valid});
      chk("flush",    {31'h0, flush_o},    {31'h0, e_flush});
      chk("trap",     {31'h0, trap_o},     {31'h0, e_trap});
      chk("if_pc",    if_pc_o,   exp_pc);
      chk("if_inst",  if_inst_o, exp_inst);
      $display("t=%0t req=%b rdy=%b stall=%b op=%h addr=%h valid=%b if_pc=%h flush=%b trap=%b",
               $time, e_req, rdy, st, op, e_addr, if_valid_o, if_pc_o, flush_o, trap_o);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_reset();
      rstn = 1'b1;

      // reset release and sequential fetch
      cyc(0, NPC_PLUS4, 0, 1, 0, 32'h0, 0, 0, 0, 0);
      cyc(0, NPC_PLUS4, 0, 1, 1, 32'h0, 1, 1, 0, 0);
      cyc(0, NPC_PLUS4, 0, 1, 1, 32'h4, 1, 1, 0, 0);
      // load-use stall at pc 8
      for (int i = 0; i < 3; i++) cyc(1, NPC_PLUS4, 0, 1, 0, 32'h8, 0, 1, 0, 0);
      cyc(0, NPC_PLUS4, 0, 1, 1, 32'h8, 1, 1, 0, 0);
      cyc(0, NPC_PLUS4, 0, 1, 1, 32'hC, 1, 1, 0, 0);
      // taken branch with a ready memory
      cyc(0, NPC_BRANCH, 32'h40, 1, 1, 32'h10, 0, 0, 1, 0);
      cyc(0, NPC_PLUS4, 0, 1, 1, 32'h40, 1, 1, 0, 0);
      // redirects while a request is stuck: drain, latest target wins
      cyc(0, NPC_PLUS4, 0, 0, 1, 32'h44, 0, 0, 0, 0);
      cyc(0, NPC_BRANCH, 32'h80, 0, 1, 32'h44, 0, 0, 1, 0);
      cyc(0, NPC_PLUS4, 0, 0, 1, 32'h44, 0, 0, 0, 0);
      cyc(0, NPC_BRANCH, 32'hC0, 0, 1, 32'h44, 0, 0, 1, 0);
      cyc(0, NPC_PLUS4, 0, 1, 1, 32'h44, 0, 0, 0, 0);
      cyc(0, NPC_PLUS4, 0, 1, 1, 32'hC0, 1, 1, 0, 0);
      // redirect beats stall
      cyc(1, NPC_JUMP, 32'h200, 1, 0, 32'hC4, 0, 0, 1, 0);
      cyc(0, NPC_PLUS4, 0, 1, 1, 32'h200, 1, 1, 0, 0);
      // misaligned target
      cyc(0, NPC_BRANCH, 32'h42, 1, 1, 32'h204, 0, 0, 1, MIS_TRAP);
      cyc(0, NPC_PLUS4, 0, 1, 1, MIS_ADDR, 1, 1, 0, 0);
      // outstanding request survives a stall; its data is refetched afterwards
      p = MIS_ADDR + 32'd4;
      cyc(0, NPC_PLUS4, 0, 0, 1, p, 0, 0, 0, 0);
      cyc(1, NPC_PLUS4, 0, 0, 1, p, 0, 0, 0, 0);
      cyc(1, NPC_PLUS4, 0, 1, 1, p, 0, 0, 0, 0);
      cyc(1, NPC_PLUS4, 0, 1, 0, p, 0, 0, 0, 0);
      cyc(0, NPC_PLUS4, 0, 1, 1, p, 1, 1, 0, 0);
      // 32-bit PC wrap
      cyc(0, NPC_JALR, 32'hFFFF_FFFC, 1, 1, p + 32'd4, 0, 0, 1, 0);
      cyc(0, NPC_PLUS4, 0, 1, 1, 32'hFFFF_FFFC, 1, 1, 0, 0);
      cyc(0, NPC_PLUS4, 0, 1, 1, 32'h0, 1, 1, 0, 0);
      // reset in the middle of a drain
      cyc(0, NPC_PLUS4, 0, 0, 1, 32'h4, 0, 0, 0, 0);
      cyc(0, NPC_BRANCH, 32'h80, 0, 1, 32'h4, 0, 0, 1, 0);
      npc_op_i = NPC_PLUS4;
      rstn     = 1'b0;
      #1;
      chk_reset();
      @(posedge clk);
      #1;
      imem_ready = 1'b1;
      rstn       = 1'b1;
      cyc(0, NPC_PLUS4, 0, 1, 0, 32'h0, 0, 0, 0, 0);
      cyc(0, NPC_PLUS4, 0, 1, 1, 32'h0, 1, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
